// File: rtl/spi_master_wb.sv
// spi_master_wb: Wishbone-attached SPI master, one byte per DATA write.
// Registers: 0 CSR, 1 DIV, 2 DATA, 3 reserved (reads zero).
// Optional macro SPI_MODE_EN: stores and honours cpol/cpha; otherwise mode 0 only.
module spi_master_wb #(
   parameter int unsigned N_CS      = 2,
   parameter int unsigned DIV_WIDTH = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [1:0]      wb_addr,
   input  logic [31:0]     wb_wdata,
   output logic [31:0]     wb_rdata,
   input  logic            wb_we,
   input  logic            wb_cyc,
   output logic            wb_ack,
   output logic            spi_sck,
   output logic            spi_mosi,
   input  logic            spi_miso,
   output logic [N_CS-1:0] spi_cs_n
);

   localparam logic [1:0] ADDR_CSR  = 2'd0;
   localparam logic [1:0] ADDR_DIV  = 2'd1;
   localparam logic [1:0] ADDR_DATA = 2'd2;

   typedef enum logic {ST_IDLE, ST_SHIFT} state_e;

   state_e               state_q, state_d;
   logic                 ack_q, ack_d;
   logic [31:0]          rdata_q, rdata_d;
   logic [DIV_WIDTH-1:0] div_q, div_d;
   logic [DIV_WIDTH-1:0] tick_q, tick_d;
   logic [3:0]           phase_q, phase_d;
   logic [N_CS-1:0]      cs_n_q, cs_n_d;
   logic                 ovr_q, ovr_d;
   logic [7:0]           rx_q, rx_d;
   logic [7:0]           sreg_q, sreg_d;
   logic                 rx_bit_q, rx_bit_d;
   logic                 mosi_q, mosi_d;
   logic                 sck_q, sck_d;
   logic                 cpol_w, cpha_w;

`ifdef SPI_MODE_EN
   logic cpol_q, cpol_d, cpha_q, cpha_d;
   assign cpol_w = cpol_q;
   assign cpha_w = cpha_q;
`else
   assign cpol_w = 1'b0;
   assign cpha_w = 1'b0;
`endif

   // Only the low bits and the mode bits of write data are meaningful
   logic unused_wdata;
   assign unused_wdata = ^wb_wdata;

   logic wr_en, rd_acc, half_end;
   assign wr_en    = ack_q & wb_cyc & wb_we;
   assign rd_acc   = wb_cyc & ~ack_q & ~wb_we;
   assign half_end = (state_q == ST_SHIFT) && (tick_q == div_q);

   // Bus decode, SCK timing and shift engine next-state
   always_comb begin
      state_d  = state_q;
      ack_d    = wb_cyc & ~ack_q;
      rdata_d  = '0;
      div_d    = div_q;
      tick_d   = tick_q;
      phase_d  = phase_q;
      cs_n_d   = cs_n_q;
      ovr_d    = ovr_q;
      rx_d     = rx_q;
      sreg_d   = sreg_q;
      rx_bit_d = rx_bit_q;
      mosi_d   = mosi_q;
      sck_d    = sck_q;
`ifdef SPI_MODE_EN
      cpol_d   = cpol_q;
      cpha_d   = cpha_q;
`endif

      if (wr_en) begin
         case (wb_addr)
            ADDR_CSR: begin
               cs_n_d = ~wb_wdata[N_CS-1:0];
               ovr_d  = 1'b0;
`ifdef SPI_MODE_EN
               cpol_d = wb_wdata[30];
               cpha_d = wb_wdata[31];
`endif
            end
            ADDR_DIV: div_d = wb_wdata[DIV_WIDTH-1:0];
            default: ;
         endcase
      end

      case (state_q)
         ST_IDLE: begin
            sck_d   = cpol_w;
            tick_d  = '0;
            phase_d = '0;
            if (wr_en && wb_addr == ADDR_DATA) begin
               state_d = ST_SHIFT;
               sreg_d  = wb_wdata[7:0];
               mosi_d  = cpha_w ? mosi_q : wb_wdata[7];
            end
         end
         ST_SHIFT: begin
            if (wr_en && wb_addr == ADDR_DATA) ovr_d = 1'b1;
            if (half_end) begin
               tick_d  = '0;
               phase_d = phase_q + 4'd1;
               sck_d   = ~sck_q;
               if (!phase_q[0]) begin
                  // leading edge
`ifdef SPI_MODE_EN
                  if (cpha_q) begin
                     mosi_d = sreg_q[7];
                     sreg_d = {sreg_q[6:0], 1'b0};
                  end else
`endif
                  begin
                     rx_bit_d = spi_miso;
                  end
               end else begin
                  // trailing edge
`ifdef SPI_MODE_EN
                  if (cpha_q) begin
                     sreg_d = {sreg_q[7:1], spi_miso};
                  end else
`endif
                  begin
                     sreg_d = {sreg_q[6:0], rx_bit_q};
                     mosi_d = sreg_q[6];
                  end
               end
               if (phase_q == 4'hf) begin
                  state_d = ST_IDLE;
                  rx_d    = sreg_d;
               end
            end else begin
               tick_d = tick_q + DIV_WIDTH'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Read data reflects register contents as they stand during the ack cycle
      if (rd_acc) begin
         case (wb_addr)
            ADDR_CSR: begin
               rdata_d[N_CS-1:0] = ~cs_n_d;
               rdata_d[28]       = ovr_d;
               rdata_d[29]       = (state_d == ST_SHIFT);
`ifdef SPI_MODE_EN
               rdata_d[30]       = cpol_d;
               rdata_d[31]       = cpha_d;
`endif
            end
            ADDR_DIV:  rdata_d[DIV_WIDTH-1:0] = div_d;
            ADDR_DATA: begin
               rdata_d[7:0] = rx_d;
               rdata_d[29]  = (state_d == ST_SHIFT);
            end
            default: rdata_d = '0;
         endcase
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         ack_q    <= 1'b0;
         rdata_q  <= '0;
         div_q    <= '0;
         tick_q   <= '0;
         phase_q  <= '0;
         cs_n_q   <= '1;
         ovr_q    <= 1'b0;
         rx_q     <= '0;
         sreg_q   <= '0;
         rx_bit_q <= 1'b0;
         mosi_q   <= 1'b0;
         sck_q    <= 1'b0;
`ifdef SPI_MODE_EN
         cpol_q   <= 1'b0;
         cpha_q   <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         ack_q    <= ack_d;
         rdata_q  <= rdata_d;
         div_q    <= div_d;
         tick_q   <= tick_d;
         phase_q  <= phase_d;
         cs_n_q   <= cs_n_d;
         ovr_q    <= ovr_d;
         rx_q     <= rx_d;
         sreg_q   <= sreg_d;
         rx_bit_q <= rx_bit_d;
         mosi_q   <= mosi_d;
         sck_q    <= sck_d;
`ifdef SPI_MODE_EN
         cpol_q   <= cpol_d;
         cpha_q   <= cpha_d;
`endif
      end
   end

   assign wb_ack   = ack_q;
   assign wb_rdata = rdata_q;
   assign spi_sck  = sck_q;
   assign spi_mosi = mosi_q;
   assign spi_cs_n = cs_n_q;

endmodule

// File: tb/tb_spi_master_wb.sv
// Bench for spi_master_wb: register table plus directed transfer sequences.
`timescale 1ns/1ps
module tb_spi_master_wb;

   localparam int unsigned N_CS = 2;
`ifdef SPI_MODE_EN
   localparam logic [31:0] MODE_BITS = 32'hC000_0000;
   localparam logic        CPOL_E    = 1'b1;
   localparam logic        CPHA_E    = 1'b1;
`else
   localparam logic [31:0] MODE_BITS = 32'h0;
   localparam logic        CPOL_E    = 1'b0;
   localparam logic        CPHA_E    = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst_n;
   logic [1:0]      wb_addr = '0;
   logic [31:0]     wb_wdata = '0;
   logic [31:0]     wb_rdata;
   logic            wb_we = 1'b0;
   logic            wb_cyc = 1'b0;
   logic            wb_ack;
   logic            spi_sck, spi_mosi, spi_miso;
   logic [N_CS-1:0] spi_cs_n;
   logic            loop_en = 1'b1;
   logic            miso_val = 1'b0;

   assign spi_miso = loop_en ? spi_mosi : miso_val;

   spi_master_wb #(.N_CS(N_CS), .DIV_WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .wb_addr(wb_addr), .wb_wdata(wb_wdata),
      .wb_rdata(wb_rdata), .wb_we(wb_we), .wb_cyc(wb_cyc), .wb_ack(wb_ack),
      .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_cs_n(spi_cs_n)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // SCK edge log, sampled mid-cycle
   int   cyc_cnt = 0;
   int   edge_t[$];
   logic edge_mosi[$];
   logic sck_prev = 1'b0;
   always @(negedge clk) begin
      cyc_cnt++;
      if (spi_sck !== sck_prev) begin
         edge_t.push_back(cyc_cnt);
         edge_mosi.push_back(spi_mosi);
      end
      sck_prev = spi_sck;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wb_acc(input logic [1:0] a, input logic we, input logic [31:0] d,
                         output logic [31:0] rd);
      int n;
      n = 0;
      rd = '0;
      wb_addr = a; wb_we = we; wb_wdata = d; wb_cyc = 1'b1;
      do begin
         @(posedge clk); #1; n++;
      end while (!wb_ack && n < 4);
      if (!wb_ack) begin
         checks++; errors++;
         $display("FAIL ack_timeout actual=0 required=1");
      end
      rd = wb_rdata;
      @(posedge clk); #1;
      wb_cyc = 1'b0; wb_we = 1'b0;
      chk("rdata_after_ack", wb_rdata, 32'h0);
   endtask

   task automatic wb_write(input logic [1:0] a, input logic [31:0] d);
      logic [31:0] dummy;
      wb_acc(a, 1'b1, d, dummy);
   endtask

   task automatic wb_read(input logic [1:0] a, output logic [31:0] d);
      wb_acc(a, 1'b0, 32'h0, d);
   endtask

   task automatic rd_chk(input string nm, input logic [1:0] a, input logic [31:0] exp);
      logic [31:0] d;
      wb_read(a, d);
      chk(nm, d, exp);
   endtask

   // Starts a transfer; base marks the first SHIFT cycle, idx the next edge slot
   task automatic start_xfer(input logic [7:0] b, output int base, output int idx);
      wb_write(2'd2, {24'h0, b});
      base = cyc_cnt + 1;
      idx  = edge_t.size();
   endtask

   task automatic wait_edges(input int idx0, input int n, input int budget);
      int c;
      c = 0;
      while (edge_t.size() < idx0 + n && c < budget) begin
         @(posedge clk); #1; c++;
      end
      if (edge_t.size() < idx0 + n) begin
         checks++; errors++;
         $display("FAIL edge_timeout actual=%0d required=%0d", edge_t.size() - idx0, n);
      end
   endtask

   task automatic check_xfer(input string nm, input int idx0, input int base, input int div,
                             input logic cpha, input logic [7:0] exp_bits);
      logic [7:0] bits;
      bits = '0;
      if (edge_t.size() >= idx0 + 16) begin
         for (int k = 0; k < 16; k++)
            if ((k % 2) == int'(cpha)) bits = {bits[6:0], edge_mosi[idx0 + k]};
         chk({nm, "_first_edge"}, 32'(edge_t[idx0] - base), 32'(div + 1));
         chk({nm, "_last_edge"}, 32'(edge_t[idx0 + 15] - base), 32'(16 * (div + 1)));
         chk({nm, "_mosi_bits"}, {24'h0, bits}, {24'h0, exp_bits});
      end
   endtask

   typedef struct {
      logic [1:0]      a;
      logic            we;
      logic [31:0]     d;
      logic [31:0]     exp;
      logic [N_CS-1:0] exp_csn;
   } vec_t;

   vec_t tbl[14];

   initial begin
      int         base, idx;
      logic [3:0] pat;
      logic [31:0] rd;

      tbl[0]  = '{2'd0, 1'b0, 32'h0,         32'h0,                 2'b11};
      tbl[1]  = '{2'd1, 1'b0, 32'h0,         32'h0,                 2'b11};
      tbl[2]  = '{2'd2, 1'b0, 32'h0,         32'h0,                 2'b11};
      tbl[3]  = '{2'd1, 1'b1, 32'h1234_5605, 32'h0,                 2'b11};
      tbl[4]  = '{2'd1, 1'b0, 32'h0,         32'h0000_0005,         2'b11};
      tbl[5]  = '{2'd0, 1'b1, 32'hC000_0003, 32'h0,                 2'b00};
      tbl[6]  = '{2'd0, 1'b0, 32'h0,         MODE_BITS | 32'h3,     2'b00};
      tbl[7]  = '{2'd3, 1'b1, 32'hFFFF_FFFF, 32'h0,                 2'b00};
      tbl[8]  = '{2'd3, 1'b0, 32'h0,         32'h0,                 2'b00};
      tbl[9]  = '{2'd0, 1'b0, 32'h0,         MODE_BITS | 32'h3,     2'b00};
      tbl[10] = '{2'd0, 1'b1, 32'h0000_0002, 32'h0,                 2'b01};
      tbl[11] = '{2'd0, 1'b0, 32'h0,         32'h0000_0002,         2'b01};
      tbl[12] = '{2'd1, 1'b1, 32'h0000_0000, 32'h0,                 2'b01};
      tbl[13] = '{2'd1, 1'b0, 32'h0,         32'h0,                 2'b01};

      // Reset
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      cycles(3);
      chk("reset_cs_n", 32'(spi_cs_n), 32'h3);
      chk("reset_sck", 32'(spi_sck), 32'h0);
      chk("reset_mosi", 32'(spi_mosi), 32'h0);
      chk("reset_ack", 32'(wb_ack), 32'h0);
      rst_n = 1'b1;
      cycles(2);

      // Register table
      for (int i = 0; i < 14; i++) begin
         if (tbl[i].we) wb_write(tbl[i].a, tbl[i].d);
         else begin
            wb_read(tbl[i].a, rd);
            chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp);
         end
         chk($sformatf("tbl%0d_cs_n", i), 32'(spi_cs_n), 32'(tbl[i].exp_csn));
      end

      // wb_cyc held: ack, gap, ack
      wb_addr = 2'd0; wb_we = 1'b0; wb_cyc = 1'b1;
      pat = '0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         pat = {pat[2:0], wb_ack};
      end
      wb_cyc = 1'b0;
      chk("held_cyc_ack_pattern", 32'(pat), 32'hA);
      cycles(2);

      // Mode 0 loopback, div 0
      wb_write(2'd0, 32'h1);
      loop_en = 1'b1;
      start_xfer(8'hA5, base, idx);
      chk("m0_cs_n_active", 32'(spi_cs_n), 32'h2);
      wait_edges(idx, 16, 40);
      cycles(2);
      chk("m0_edge_count", 32'(edge_t.size() - idx), 32'd16);
      check_xfer("m0", idx, base, 0, 1'b0, 8'hA5);
      rd_chk("m0_data", 2'd2, 32'h0000_00A5);

      // Divider 3, MISO high: busy boundary on both sides
      wb_write(2'd1, 32'h3);
      loop_en = 1'b0; miso_val = 1'b1;
      start_xfer(8'h3C, base, idx);
      cycles(62);
      rd_chk("div3_last_busy_cycle", 2'd2, 32'h2000_00A5);
      wait_edges(idx, 16, 100);
      cycles(2);
      check_xfer("div3", idx, base, 3, 1'b0, 8'h3C);
      start_xfer(8'h3C, base, idx);
      cycles(63);
      rd_chk("div3_first_idle_cycle", 2'd2, 32'h0000_00FF);

      // Overrun
      loop_en = 1'b1;
      start_xfer(8'h11, base, idx);
      wb_write(2'd2, 32'h22);
      wait_edges(idx, 16, 100);
      cycles(2);
      chk("ovr_edge_count", 32'(edge_t.size() - idx), 32'd16);
      check_xfer("ovr", idx, base, 3, 1'b0, 8'h11);
      rd_chk("ovr_csr", 2'd0, 32'h1000_0001);
      rd_chk("ovr_rx", 2'd2, 32'h0000_0011);
      wb_write(2'd0, 32'h1);
      rd_chk("ovr_cleared", 2'd0, 32'h0000_0001);

      // Back-to-back, div 0
      wb_write(2'd1, 32'h0);
      start_xfer(8'h81, base, idx);
      cycles(15);
      wb_write(2'd2, 32'h7E);
      wait_edges(idx, 32, 60);
      cycles(2);
      chk("b2b_edge_count", 32'(edge_t.size() - idx), 32'd32);
      check_xfer("b2b_a", idx, base, 0, 1'b0, 8'h81);
      check_xfer("b2b_b", idx + 16, base + 17, 0, 1'b0, 8'h7E);
      rd_chk("b2b_csr", 2'd0, 32'h0000_0001);
      rd_chk("b2b_rx", 2'd2, 32'h0000_007E);

      // Mode 3 request, div 1
      wb_write(2'd1, 32'h1);
      wb_write(2'd0, 32'hC000_0001);
      cycles(2);
      chk("m3_sck_idle", 32'(spi_sck), 32'(CPOL_E));
      rd_chk("m3_csr", 2'd0, MODE_BITS | 32'h1);
      start_xfer(8'h5A, base, idx);
      wait_edges(idx, 16, 60);
      cycles(2);
      check_xfer("m3", idx, base, 1, CPHA_E, 8'h5A);
      chk("m3_sck_end", 32'(spi_sck), 32'(CPOL_E));
      rd_chk("m3_rx", 2'd2, 32'h0000_005A);

      // Slowest divider
      wb_write(2'd0, 32'h1);
      wb_write(2'd1, 32'hFF);
      loop_en = 1'b0; miso_val = 1'b0;
      start_xfer(8'hC3, base, idx);
      wait_edges(idx, 16, 16 * 256 + 20);
      cycles(2);
      check_xfer("divmax", idx, base, 255, 1'b0, 8'hC3);
      rd_chk("divmax_rx", 2'd2, 32'h0000_0000);

      // Reset during half-period 7
      wb_write(2'd1, 32'h3);
      loop_en = 1'b1;
      start_xfer(8'h55, base, idx);
      cycles(28);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_sck", 32'(spi_sck), 32'h0);
      chk("rst_mid_mosi", 32'(spi_mosi), 32'h0);
      chk("rst_mid_cs_n", 32'(spi_cs_n), 32'h3);
      chk("rst_mid_ack", 32'(wb_ack), 32'h0);
      chk("rst_mid_rdata", wb_rdata, 32'h0);
      cycles(2);
      rst_n = 1'b1;
      cycles(2);
      rd_chk("rst_mid_csr", 2'd0, 32'h0);
      rd_chk("rst_mid_data", 2'd2, 32'h0);
      rd_chk("rst_mid_div", 2'd1, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
